// File: rtl/sine_pkg.sv
// Shared float32 / Q1.15 definitions for the sine result receive path.
package sine_pkg;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;

  typedef logic signed [15:0] q15_t;

  localparam q15_t Q15_MAX = 16'sh7fff;
  localparam q15_t Q15_MIN = 16'sh8000;
endpackage

// File: rtl/f32_to_q15.sv
// Combinational IEEE-754 single to Q1.15 converter, round half away from zero.
module f32_to_q15
  import sine_pkg::*;
(
  input  logic [31:0] f,
  output q15_t        q,
  output logic        is_nan
);
  logic                 sgn;
  logic [F32_EXP_W-1:0] e;
  logic [F32_MAN_W-1:0] m;
  logic [F32_MAN_W:0]   mant;
  logic [7:0]           sh;
  logic [25:0]          rnd;

  always_comb begin
    sgn    = f[31];
    e      = f[F32_MAN_W +: F32_EXP_W];
    m      = f[F32_MAN_W-1:0];
    mant   = {1'b1, m};
    sh     = 8'(F32_BIAS + 8) - e;
    rnd    = '0;
    q      = '0;
    is_nan = 1'b0;
    if (e == '0) begin
      q = '0;
    end else if (e == '1 && m != '0) begin
      is_nan = 1'b1;
    end else if (e >= 8'(F32_BIAS)) begin
      q = sgn ? Q15_MIN : Q15_MAX;
    end else begin
      // Magnitude is 1.m scaled into Q15; shifts of 25+ leave nothing to round.
      if (sh < 8'd25) rnd = ({2'b00, mant} + (26'd1 << (sh - 8'd1))) >> sh;
      if (sgn) q = q15_t'(-rnd[15:0]);
      else     q = (rnd >= 26'd32768) ? Q15_MAX : q15_t'(rnd[15:0]);
    end
  end
endmodule

// File: rtl/sine_result_rx.sv
// Tracks sine-core latency, captures and converts results to Q1.15, and
// buffers them in a credit-controlled FIFO with sticky NaN/overflow flags.
module sine_result_rx
  import sine_pkg::*;
#(
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_flags,
  output logic        nan_flag,
  output logic        ovf_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic               res_vld_q, res_vld_d;
  logic [31:0]        res_q, res_d;
  logic               conv_vld_q, conv_vld_d;
  q15_t               conv_data_q, conv_data_d;
  logic               conv_nan_q, conv_nan_d;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               nan_q, nan_d, ovf_q, ovf_d;
  q15_t               mem_q [DEPTH];

  q15_t        cvt_q15;
  logic        cvt_nan;
  logic        tap, push, pop, full, push_ok;
  logic [31:0] inflight;

  f32_to_q15 u_cvt (.f(res_q), .q(cvt_q15), .is_nan(cvt_nan));

  always_comb begin
    tap         = vld_pipe_q[LATENCY-1];
    vld_pipe_d  = (vld_pipe_q << 1) | LATENCY'(in_valid);
    res_vld_d   = tap;
    res_d       = tap ? result : res_q;
    conv_vld_d  = res_vld_q;
    conv_data_d = res_vld_q ? cvt_q15 : conv_data_q;
    conv_nan_d  = res_vld_q & cvt_nan;

    out_valid = (cnt_q != '0);
    out_data  = out_valid ? mem_q[rptr_q] : '0;
    push      = conv_vld_q;
    pop       = out_valid & out_ready;
    full      = (cnt_q == CW'(DEPTH));
    push_ok   = push & ~full;
    wptr_d    = wptr_q + AW'(push_ok);
    rptr_d    = rptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push_ok) - CW'(pop);

    // Every sample still in the pipe owns a FIFO slot, so accepted work never overflows.
    inflight = 32'(res_vld_q) + 32'(conv_vld_q);
    for (int i = 0; i < LATENCY; i++) inflight = inflight + 32'(vld_pipe_q[i]);
    in_ready = reset & ((32'(cnt_q) + inflight) < 32'(DEPTH));

    nan_d = clr_flags ? 1'b0 : nan_q;
    if (conv_vld_q & conv_nan_q) nan_d = 1'b1;
    ovf_d = clr_flags ? 1'b0 : ovf_q;
    if (push & full) ovf_d = 1'b1;

    nan_flag = nan_q;
    ovf_flag = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      conv_vld_q  <= 1'b0;
      conv_data_q <= '0;
      conv_nan_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      res_vld_q   <= res_vld_d;
      res_q       <= res_d;
      conv_vld_q  <= conv_vld_d;
      conv_data_q <= conv_data_d;
      conv_nan_q  <= conv_nan_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= conv_data_q;
  end
endmodule
